mmio_uart_tx: RTL

//  Memory-mapped UART transmitter on the RV32I_CPU data port, downstream of the memory stage.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 46 ++++
 rtl/mmio_uart_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// frame FSM encoding and STATUS bit positions.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned STAT_FULL      = 0;
  localparam int unsigned STAT_EMPTY     = 1;
  localparam int unsigned STAT_BUSY      = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;

  // A divider of zero would never produce a bit boundary, so it is held at one.
  function automatic logic [15:0] sanitize_div(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; pop has priority so a push into a
// full FIFO is accepted when it coincides with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud counter and
// frame FSM. Read data is registered so it lines up with the CPU writeback stage.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [9:0]  BASE_ADDR  = 10'h3F0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  data_address,
  input  logic [31:0] data_out,
  input  logic [3:0]  width,
  input  logic        write_mem,
  output logic [31:0] rdata,
  output logic        rsel,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [1:0]    reg_sel;
  logic          wr_txdata, wr_status_clr, wr_baud;
  logic [15:0]   baud_q, baud_d, baud_wr, div_load;
  logic          ovf_q, ovf_d;
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  uart_state_e   state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [2:0]    bitidx_q, bitidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_end, busy;
  logic [31:0]   status, reg_rdata, rdata_q;
  logic          rsel_q;
  logic          unused_bits;

  assign unused_bits = ^{data_out[31:16], width[3:2]};

  // Register decode
  assign hit     = (data_address[9:4] == BASE_ADDR[9:4]);
  assign reg_sel = data_address[3:2];

  assign wr_txdata     = write_mem & hit & (reg_sel == REG_TXDATA) & width[0];
  assign wr_status_clr = write_mem & hit & (reg_sel == REG_STATUS) & width[0] & data_out[3];
  assign wr_baud       = write_mem & hit & (reg_sel == REG_BAUDDIV) & (|width[1:0]);

  always_comb begin
    baud_wr = baud_q;
    if (width[0]) baud_wr[7:0]  = data_out[7:0];
    if (width[1]) baud_wr[15:8] = data_out[15:8];
    baud_d = wr_baud ? sanitize_div(baud_wr) : baud_q;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end else if (wr_status_clr) begin
      ovf_d = 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (wr_txdata),
    .wdata (data_out[7:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Frame FSM; baud_div is sampled only when a bit starts, so divider writes
  // never stretch or cut the bit in flight.
  assign div_load = baud_q - 16'd1;
  assign bit_end  = (cnt_q == 16'd0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shreg_d  = shreg_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          cnt_d    = div_load;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bitidx_d = 3'd0;
          cnt_d    = div_load;
          state_d  = S_DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = div_load;
          if (bitidx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitidx_d = bitidx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line tracks state_q.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shreg_d[bitidx_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  always_comb begin
    status                              = '0;
    status[STAT_FULL]                   = fifo_full;
    status[STAT_EMPTY]                  = fifo_empty;
    status[STAT_BUSY]                   = busy;
    status[STAT_OVF]                    = ovf_q;
    status[STAT_COUNT_LSB +: 8]         = 8'(fifo_count);
  end

  always_comb begin
    reg_rdata = '0;
    if (hit) begin
      case (reg_sel)
        REG_STATUS:  reg_rdata = status;
        REG_BAUDDIV: reg_rdata = {16'b0, baud_q};
        default:     reg_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitidx_q <= '0;
      shreg_q  <= '0;
      tx_q     <= 1'b1;
      baud_q   <= sanitize_div(DIV_RESET);
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      rsel_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitidx_q <= bitidx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      baud_q   <= baud_d;
      ovf_q    <= ovf_d;
      rdata_q  <= reg_rdata;
      rsel_q   <= hit;
    end
  end

  assign rdata = rdata_q;
  assign rsel  = rsel_q;
  assign tx    = tx_q;
  assign irq   = fifo_empty & ~busy;

endmodule
